// File: rtl/periph_bus_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter.
//   state_e   : sequencer state encoding (idle / grant / response)
//   M0, M1    : master index constants (CPU data port, secondary master)
//   Def*      : default bus widths
package periph_bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StResp  = 2'd2
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned DefAddrW = 11;
  localparam int unsigned DefDataW = 32;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way arbiter.
//   req        : {req1, req0} pending requests
//   ptr        : last granted master; on a tie the other master wins
//   grant      : index of the winning master (M0/M1)
//   valid      : at least one request pending
//   FIXED_PRIO : nonzero makes M0 win every tie regardless of ptr
module rr_arbiter_2
  import periph_bus_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = M0;
    unique case (req)
      2'b01:   grant = M0;
      2'b10:   grant = M1;
      2'b11:   grant = (FIXED_PRIO != 0) ? M0 : ~ptr;
      default: grant = M0;
    endcase
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared memory/peripheral bus.
// One transaction at a time: IDLE samples requests, GRANT drives the bus
// (writes commit, reads are captured at the end of the cycle), RESP pulses
// the owner's ack.
//   clk, rst_n                : clock, synchronous active-low reset
//   m{0,1}_req/we/addr/wdata  : master transaction inputs, stable while req
//   m{0,1}_ack                : one-cycle completion pulse
//   m{0,1}_rdata              : read data, held until the next read completes
//   bus_we/addr/wdata         : shared bus drive, all zero outside GRANT
//   bus_rdata                 : combinational read data from the bus
//   busy                      : high in GRANT or RESP
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              ptr_q, ptr_d;

  logic arb_grant;
  logic arb_valid;

  rr_arbiter_2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .req  ({m1_req, m0_req}),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .valid(arb_valid)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    ptr_d      = ptr_q;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          owner_d = arb_grant;
          if (arb_grant == M1) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
          state_d = StGrant;
        end
      end
      StGrant: begin
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        // Reads land only in the owner's register; writes leave both alone.
        if (!we_q) begin
          if (owner_q == M1) begin
            m1_rdata_d = bus_rdata;
          end else begin
            m0_rdata_d = bus_rdata;
          end
        end
        state_d = StResp;
      end
      StResp: begin
        m0_ack  = (owner_q == M0);
        m1_ack  = (owner_q == M1);
        ptr_d   = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= M0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      // Pointer starts at M1 so the first tie goes to M0.
      ptr_q      <= M1;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      ptr_q      <= ptr_d;
    end
  end

  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter with an ack scoreboard.
// Instance dut uses round-robin; dut_fp uses fixed priority and shares the
// master request inputs.
module tb_periph_bus_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          busy;

  logic          fp_m0_ack, fp_m1_ack;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic          fp_bus_we;
  logic [AW-1:0] fp_bus_addr;
  logic [DW-1:0] fp_bus_wdata, fp_bus_rdata;
  logic          fp_busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic        master;
    logic        is_read;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  logic [DW-1:0] mem [0:255];

  int  fp_m0_cnt = 0;
  int  fp_m1_cnt = 0;
  logic fp_cnt_en = 1'b0;

  periph_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  periph_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
    .bus_we(fp_bus_we), .bus_addr(fp_bus_addr), .bus_wdata(fp_bus_wdata),
    .bus_rdata(fp_bus_rdata), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: bit 10 selects a peripheral that always reads 0x0000000A.
  assign bus_rdata    = bus_addr[10] ? 32'h0000_000A : mem[bus_addr[9:2]];
  assign fp_bus_rdata = {21'b0, fp_bus_addr};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (bus_we && !bus_addr[10]) mem[bus_addr[9:2]] <= bus_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (m0_ack || m1_ack)) begin
      check("ack_one_hot", 32'(m0_ack & m1_ack), 32'd0);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ack: observed m0_ack=%b m1_ack=%b at cycle %0d expected none",
               m0_ack, m1_ack, cyc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_master", 32'(m1_ack), 32'(e.master));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_read) check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (fp_cnt_en) begin
      if (fp_m0_ack) fp_m0_cnt++;
      if (fp_m1_ack) fp_m1_cnt++;
    end
  end

  task automatic push(input logic m, input logic rd, input logic [31:0] d, input int c);
    exp_t e;
    e.master  = m;
    e.is_read = rd;
    e.rdata   = d;
    e.cyc     = c;
    sb.push_back(e);
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  task automatic check_bus_grant(input string tag, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_bus_we"}, 32'(bus_we), 32'(w));
    check({tag, "_bus_addr"}, 32'(bus_addr), 32'(a));
    check({tag, "_bus_wdata"}, bus_wdata, d);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_m0_ack"}, 32'(m0_ack), 32'd0);
    check({tag, "_m1_ack"}, 32'(m1_ack), 32'd0);
    check({tag, "_bus_we"}, 32'(bus_we), 32'd0);
    check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Single transaction from an idle arbiter: GRANT, RESP, then back to IDLE.
  task automatic run_single(input logic m, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [31:0] exp_rd);
    push(m, !w, exp_rd, cyc + 2);
    if (m == 1'b1) set_m1(1'b1, w, a, d);
    else set_m0(1'b1, w, a, d);
    @(negedge clk);
    check_bus_grant("single_grant", w, a, d);
    @(negedge clk);
    check("single_resp_bus_we", 32'(bus_we), 32'd0);
    if (m == 1'b1) set_m1(1'b0, 1'b0, '0, '0);
    else set_m0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_quiet("single_idle");
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    set_m0(1'b1, 1'b1, 11'h004, 32'hDEAD_BEEF);
    set_m1(1'b1, 1'b1, 11'h400, 32'h0000_007F);

    // Reset held across several edges with both masters requesting.
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_m0_rdata", m0_rdata, 32'd0);
    check("reset_m1_rdata", m1_rdata, 32'd0);

    // Release: the tie goes to M0, M1 follows three cycles later.
    c = cyc;
    rst_n = 1'b1;
    push(1'b0, 1'b0, 32'd0, c + 2);
    push(1'b1, 1'b0, 32'd0, c + 5);
    @(negedge clk);
    check_bus_grant("first_m0_write", 1'b1, 11'h004, 32'hDEAD_BEEF);
    @(negedge clk);
    check("first_resp_bus_we", 32'(bus_we), 32'd0);
    set_m0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("first_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_bus_grant("first_m1_write", 1'b1, 11'h400, 32'h0000_007F);
    @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_quiet("after_writes");
    check("writes_keep_m0_rdata", m0_rdata, 32'd0);
    check("writes_keep_m1_rdata", m1_rdata, 32'd0);

    run_single(1'b0, 1'b0, 11'h004, 32'd0, 32'hDEAD_BEEF);
    check("m0_read_keeps_m1", m1_rdata, 32'd0);
    check("m0_rdata_held", m0_rdata, 32'hDEAD_BEEF);

    run_single(1'b0, 1'b1, 11'h010, 32'h5555_AAAA, 32'd0);
    check("m0_write_keeps_rdata", m0_rdata, 32'hDEAD_BEEF);

    run_single(1'b1, 1'b0, 11'h400, 32'd0, 32'h0000_000A);
    check("periph_m1_rdata", m1_rdata, 32'h0000_000A);
    check("periph_keeps_m0", m0_rdata, 32'hDEAD_BEEF);

    // Contention: both held for four transactions.
    c = cyc;
    set_m0(1'b1, 1'b0, 11'h010, 32'd0);
    set_m1(1'b1, 1'b0, 11'h400, 32'd0);
    push(1'b0, 1'b1, 32'h5555_AAAA, c + 2);
    push(1'b1, 1'b1, 32'h0000_000A, c + 5);
    push(1'b0, 1'b1, 32'h5555_AAAA, c + 8);
    push(1'b1, 1'b1, 32'h0000_000A, c + 11);
    fp_m0_cnt = 0;
    fp_m1_cnt = 0;
    fp_cnt_en = 1'b1;
    repeat (11) @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    fp_cnt_en = 1'b0;
    check("fixed_prio_m0_acks", 32'(fp_m0_cnt), 32'd4);
    check("fixed_prio_m1_acks", 32'(fp_m1_cnt), 32'd0);
    check("contention_pending", 32'(sb.size()), 32'd0);

    // Late request: M1 arrives while M0 is in GRANT.
    c = cyc;
    set_m0(1'b1, 1'b1, 11'h008, 32'h1234_5678);
    push(1'b0, 1'b0, 32'd0, c + 2);
    @(negedge clk);
    set_m1(1'b1, 1'b0, 11'h008, 32'd0);
    push(1'b1, 1'b1, 32'h1234_5678, c + 5);
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check_quiet("late_done");
    check("late_pending", 32'(sb.size()), 32'd0);

    // Reset during RESP of an M0 read: ack suppressed, rdata cleared.
    set_m0(1'b1, 1'b0, 11'h008, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check_quiet("mid_reset");
    check("mid_reset_m0_rdata", m0_rdata, 32'd0);
    check("mid_reset_m1_rdata", m1_rdata, 32'd0);

    // Pointer back at M1 after reset: a tie grants M0 first.
    c = cyc;
    rst_n = 1'b1;
    set_m0(1'b1, 1'b0, 11'h004, 32'd0);
    set_m1(1'b1, 1'b0, 11'h400, 32'd0);
    push(1'b0, 1'b1, 32'hDEAD_BEEF, c + 2);
    push(1'b1, 1'b1, 32'h0000_000A, c + 5);
    repeat (2) @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_quiet("final");
    check("final_pending", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
